uart_tx_engine: RTL
===================

Name: uart_tx_engine

Overview:
- Consumer side of the 2-bit transmit-control register written by the CPU. Turns control bits plus a data byte into an 8N1 UART serial frame.
- Returns a CPU-readable status word (busy, done) through the same rd/sel bus strobe style.
- Sits in the IO interface between the control/data registers and the TX pin.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535
- DATA_W, 8, payload bits per frame

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset, asynchronous, active-low
- ctl_data_i  in  2  control register contents: bit0 = start request, bit1 = transmitter enable
- tx_data_i  in  DATA_W  byte to send; sampled only at frame start
- rd_i  in  1  CPU read strobe
- sel_i  in  1  address decode select for the status word
- status_o  out  2  {done, busy}
- tx_o  out  1  serial line, idle high

Behaviour:
- Reset (async):
  - state = IDLE, tx_o = 1, busy = 0, done = 0.
  - Baud counter, bit counter, data shift register and start_q all cleared.
  - Reset mid-frame forces tx_o high immediately and does not wait for a clock edge.
- Start detection:
  - start_q is a registered copy of ctl_data_i[0].
  - go = ctl_data_i[1] & ctl_data_i[0] & ~start_q & (state == IDLE).
  - Only a rising edge of the start bit launches a frame. A level held high never retransmits.
  - A rising edge while busy is ignored, with no queueing. start_q still updates.
- Launch, on the edge where go = 1:
  - shift register <= tx_data_i.
  - state <= START, tx_o <= 0, busy <= 1, baud counter <= 0.
  - Latency: tx_o falls 1 cycle after ctl_data_i[0] rises.
- Bit timing: each of START, DATA and STOP lasts exactly CLKS_PER_BIT cycles. The baud tick fires when the counter equals CLKS_PER_BIT-1, then the counter wraps to 0.
- FSM, all transitions taken on tick:
  - IDLE: tx_o = 1. go -> START.
  - START: tx_o = 0. On tick -> DATA, with tx_o = shift[0] and bit count = 0.
  - DATA: LSB first. On tick, shift right. If bit count == DATA_W-1 -> STOP with tx_o = 1; else increment bit count.
  - STOP: tx_o = 1. On tick -> IDLE, busy <= 0, done <= 1.
  - Full frame = (DATA_W+2)*CLKS_PER_BIT cycles.
- Enable drop: ctl_data_i[1] = 0 in any non-IDLE state aborts the frame on the next edge.
  - State goes to IDLE, tx_o = 1, busy = 0.
  - done is not set.
- done handling:
  - done is sticky. It is cleared on the edge where rd_i & sel_i = 1.
  - The CPU sees done = 1 during its read cycle because status_o is combinational from the registers.
  - If a set and a clear occur on the same edge, the set wins.
- status_o = {done, busy}. It is driven regardless of sel_i.
- tx_o is a registered output, glitch-free.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum (IDLE, START, DATA, STOP, 2 bits).
  - Status bit indices: ST_BUSY = 0, ST_DONE = 1.
  - Control bit indices: CTL_START = 0, CTL_EN = 1.
- One sub-module, uart_baud_tick:
  - Parameterised counter with a clear input and a tick output.
  - Active only while the FSM is not IDLE; cleared on launch and on abort.

Test Plan (CLKS_PER_BIT = 4):
- Reset, then idle 20 cycles -> tx_o = 1, status_o = 2'b00.
- tx_data_i = 8'hA5, ctl 2'b10 then 2'b11:
  - tx_o low 1 cycle after the edge.
  - Then 4-cycle bits: 0, 1,0,1,0,0,1,0,1, 1.
  - busy = 1 for exactly 40 cycles, then status_o = 2'b10.
- After done = 1, pulse rd_i & sel_i -> done = 1 during the read cycle, 2'b00 on the next cycle. Assert rd_i & sel_i on the exact STOP-tick edge -> done stays 1.
- Hold ctl = 2'b11 for 100 cycles -> exactly one frame. A second rising edge of bit0 in mid-frame -> no second frame.
- Drop ctl[1] at cycle 12 of an 8'h3C frame -> tx_o = 1 and busy = 0 the next cycle, done stays 0.
- Assert rst_ni low mid-DATA -> tx_o = 1 asynchronously, status_o = 2'b00. A new frame after reset transmits correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================
// uart_pkg: shared FSM encoding and register bit indices for the UART TX path.
// Revision: 1.0
// ============================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int ST_BUSY   = 0;
    localparam int ST_DONE   = 1;
    localparam int CTL_START = 0;
    localparam int CTL_EN    = 1;

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================
// uart_baud_tick: bit-period counter producing one tick every CLKS_PER_BIT cycles.
// Revision: 1.0
// ============================================================
`default_nettype none

module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tick = enable && (cnt_q == LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_engine.sv
// ============================================================
// uart_tx_engine: 8N1 UART transmitter launched by a rising edge of the CPU start bit.
// Revision: 1.0
// ============================================================
`default_nettype none

module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_W       = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [1:0]        ctl_data_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              rd_i,
    input  logic              sel_i,
    output logic [1:0]        status_o,
    output logic              tx_o
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              start_q;
    logic              done_set;
    logic              go;
    logic              abort;
    logic              tick;

    assign go    = ctl_data_i[CTL_EN] & ctl_data_i[CTL_START] & ~start_q & (state_q == IDLE);
    assign abort = ~ctl_data_i[CTL_EN] & (state_q != IDLE);

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clear  (go | abort),
        .enable (state_q != IDLE),
        .tick   (tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_set  = 1'b0;

        if (abort) begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_d = 1'b1;
                    if (go) begin
                        shift_d = tx_data_i;
                        state_d = START;
                        tx_d    = 1'b0;
                        busy_d  = 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        state_d   = DATA;
                        tx_d      = shift_q[0];
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_d = shift_q >> 1;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                            tx_d      = shift_d[0];
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        state_d  = IDLE;
                        busy_d   = 1'b0;
                        done_set = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            endcase
        end

        // A completion on the same edge as a CPU read must not be lost.
        if (done_set) begin
            done_d = 1'b1;
        end else if (rd_i && sel_i) begin
            done_d = 1'b0;
        end else begin
            done_d = done_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            start_q   <= ctl_data_i[CTL_START];
        end
    end

    assign tx_o              = tx_q;
    assign status_o[ST_BUSY] = busy_q;
    assign status_o[ST_DONE] = done_q;

endmodule

`default_nettype wire
